// File: rtl/rr_stream_demux.sv
// Round-robin demultiplexer: one valid/ready word stream spread across N one-entry lane registers.
// Define RR_DEMUX_SKIP_BUSY_EN to let a word bypass busy lanes and go to the next free one.
module rr_stream_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [WIDTH-1:0]       up_data,
  output logic [N-1:0]           down_valid,
  input  logic [N-1:0]           down_ready,
  output logic [N*WIDTH-1:0]     down_data,
  output logic [$clog2(N)-1:0]   lane_ptr
);

  localparam int unsigned PW = $clog2(N);

  logic [N-1:0]       full;
  logic [N-1:0]       avail;
  logic [N*WIDTH-1:0] data_q;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      target;
  logic [PW-1:0]      ptr_next;
  logic               ready;
  logic               up_fire;
`ifdef RR_DEMUX_SKIP_BUSY_EN
  logic               found;
  int unsigned        idx;
`endif

  // A lane can take a word when it is empty or its consumer is draining it now.
  assign avail = ~full | down_ready;

  always_comb begin
    target = ptr;
    ready  = 1'b0;
`ifdef RR_DEMUX_SKIP_BUSY_EN
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && avail[PW'(idx)]) begin
        found  = 1'b1;
        target = PW'(idx);
      end
    end
    ready = found;
`else
    ready = avail[ptr];
`endif
    if (rst) ready = 1'b0;
  end

  assign ptr_next = (target == PW'(N - 1)) ? '0 : target + 1'b1;
  assign up_fire  = up_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      data_q <= '0;
      ptr    <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        // Refill wins over drain so a lane loaded while draining stays full.
        if (up_fire && target == PW'(i)) begin
          full[i]                    <= 1'b1;
          data_q[i*WIDTH +: WIDTH]   <= up_data;
        end else if (down_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (up_fire) ptr <= ptr_next;
    end
  end

  assign up_ready   = ready;
  assign down_valid = full;
  assign down_data  = data_q;
  assign lane_ptr   = ptr;

endmodule

// File: doc/rr_stream_demux.md
# rr_stream_demux

- Distributes one upstream valid/ready word stream across `N` downstream lanes in strict round-robin order; this is the demultiplexing counterpart of the team's mux-based selection blocks.
- Each lane owns a one-entry output register, so every accepted word reaches its lane one cycle after acceptance.
- Sits between a single producer and `N` parallel consumers, e.g. to spread work across identical processing units.

## Interface
Parameters:
- `WIDTH`, default 8: data word width in bits.
- `N`, default 4: number of downstream lanes; allowed range 2..16.

Ports:
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous reset, active-high.
- `up_valid`  input  1: upstream word present.
- `up_ready`  output  1: block accepts the upstream word this cycle.
- `up_data`  input  `WIDTH`: upstream word.
- `down_valid`  output  `N`: bit i high means lane i holds a word.
- `down_ready`  input  `N`: bit i high means consumer i takes lane i's word this cycle.
- `down_data`  output  `N*WIDTH`: lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `lane_ptr`  output  `$clog2(N)`: index of the lane that receives the next word.

## Operation
- Transfers:
  - Upstream transfer occurs when `up_valid && up_ready`.
  - Lane i transfer occurs when `down_valid[i] && down_ready[i]`.
- Lane state: each lane register is EMPTY or FULL. `down_valid[i]` is 1 exactly when lane i is FULL.
- Target lane is `lane_ptr`. Without the configuration macro:
  - `up_ready = !down_valid[lane_ptr] || down_ready[lane_ptr]`.
  - This is combinational from `lane_ptr`, lane state and `down_ready`. It does not depend on `up_valid`.
- On an upstream transfer:
  - Lane `lane_ptr` loads `up_data` and becomes FULL.
  - `lane_ptr` advances by 1. It wraps from `N-1` to 0, including when `N` is not a power of two.
- On a lane drain with no refill in the same cycle, the lane becomes EMPTY. Its `down_data` holds its last value.
- Drain and refill of the same lane in the same cycle: the lane stays FULL with the new word, so full throughput is maintained.
- Each lane keeps its contents independently. A stalled consumer on lane i blocks upstream only when `lane_ptr == i`.
- `lane_ptr` does not move without an upstream transfer.
- Reset, at the clock edge with `rst` high:
  - All lanes become EMPTY.
  - `down_valid` = 0, `down_data` = 0, `lane_ptr` = 0.
  - Any word offered in that cycle is not accepted: `up_ready` is forced to 0 while `rst` is high.
  - A mid-stream reset discards all buffered words.

## Timing
- Latency: a word accepted at edge k shows `down_valid` high immediately after edge k (1 cycle).
- Throughput: 1 word per cycle while target lanes drain.
- `up_ready` settles within the same cycle from registered state and `down_ready`. There is no combinational path from `up_valid` or `up_data` to any output.
- All state changes occur on the rising edge of `clk` only.

## Configuration
- Macro `RR_DEMUX_SKIP_BUSY_EN`.
- Undefined: strict round-robin. Upstream stalls while lane `lane_ptr` is FULL and not draining.
- Defined:
  - The target is the first lane, searching circularly from `lane_ptr`, that is EMPTY or draining this cycle.
  - `up_ready` is 1 if any such lane exists.
  - After a transfer, `lane_ptr` becomes target+1, with wrap.
  - Lane order is then no longer strictly periodic.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst` 2 cycles, then release with `up_valid`=0.
  - Required: `down_valid`=0, `lane_ptr`=0 and `up_ready`=1 on every cycle.
- Streaming (N=4, WIDTH=8, all `down_ready`=1):
  - Stimulus: send 0x10..0x17 back-to-back.
  - Required: lanes 0,1,2,3,0,1,2,3 receive them in order. Each is valid exactly 1 cycle after its acceptance cycle. No stall.
- Stalled lane:
  - Stimulus: `down_ready[2]`=0; send 0xA0..0xA6.
  - Required: 0xA2 sits in lane 2. After 0xA5, `up_ready`=0 with `lane_ptr`=2.
  - Release `down_ready[2]`. Required: 0xA2 drains, 0xA6 loads in that same cycle, and `lane_ptr` becomes 3.
- Wrap with N=3: six words go to lanes 0,1,2,0,1,2, and `lane_ptr` never reaches 3.
- Reset mid-operation:
  - Stimulus: assert `rst` with lanes 0 and 1 FULL and `up_valid`=1.
  - Required: the next cycle shows `down_valid`=0 and `lane_ptr`=0. No word is lost or duplicated after release.
- Macro defined:
  - Stimulus: lane 1 FULL and stalled, `lane_ptr`=1; send 0x55.
  - Required: 0x55 goes to lane 2, and `lane_ptr` becomes 3.
